// File: rtl/instr_seq_pkg.sv
// Shared encodings for the instruction sequencer.
// States, instruction classes, PC source selects and watchdog default.
package instr_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_WB     = 4'd4,
    S_MADDR  = 4'd5,
    S_MACC   = 4'd6,
    S_BRANCH = 4'd7,
    S_FAULT  = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CLS_DP  = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_RSV = 2'b11
  } cls_t;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_ALU = 2'b10;

  localparam logic [3:0] RD_PC        = 4'hF;
  localparam logic [7:0] WDOG_DEFAULT = 8'd255;

endpackage

// File: rtl/seq_watchdog.sv
// Memory-ack watchdog: counts stalled access cycles.
// expired flags the cycle whose stall would reach max.
module seq_watchdog (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] max,
  output logic       expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt + 8'd1) == max;

endmodule

// File: rtl/instr_sequencer.sv
// Moore control sequencer: fetch/decode/execute/memory/branch.
// Strobes are decoded from the registered state and ir only.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter logic [7:0] WDOG_MAX = WDOG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic [31:0] ir,
  input  logic        cond_ok,
  input  logic        mem_ack,
  output logic        write_ir,
  output logic        write_pc,
  output logic [1:0]  pc_s,
  output logic        alu_en,
  output logic        set_flags,
  output logic        write_reg,
  output logic        link_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        busy,
  output logic        fault,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  state_t      cur, nxt;
  logic        cond_q;
  logic [31:0] retired_q;
  logic        boundary;
  logic        wd_clr, wd_en, wd_exp;
  logic        is_load;
  logic        unused_ir;

  assign is_load   = ir[20];
  assign unused_ir = ^{ir[31:28], ir[25], ir[23:21],
                       ir[19:16], ir[11:0]};

  seq_watchdog u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clr),
    .enable  (wd_en),
    .max     (WDOG_MAX),
    .expired (wd_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= S_IDLE;
      cond_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH) begin
        cond_q <= cond_ok;
      end
      if (boundary) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  always_comb begin
    nxt       = cur;
    write_ir  = 1'b0;
    write_pc  = 1'b0;
    pc_s      = PCS_SEQ;
    alu_en    = 1'b0;
    set_flags = 1'b0;
    write_reg = 1'b0;
    link_sel  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    boundary  = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    unique case (cur)
      S_IDLE: begin
        if (start) nxt = S_FETCH;
      end
      S_FETCH: begin
        write_ir = 1'b1;
        write_pc = 1'b1;
        pc_s     = PCS_SEQ;
        nxt      = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_q) begin
          boundary = 1'b1;
        end else begin
          unique case (cls_t'(ir[27:26]))
            CLS_DP:  nxt = S_EXEC;
            CLS_MEM: nxt = S_MADDR;
            CLS_BR:  nxt = S_BRANCH;
            CLS_RSV: nxt = S_FAULT;
          endcase
        end
      end
      S_EXEC: begin
        alu_en    = 1'b1;
        set_flags = ir[20];
        nxt       = S_WB;
      end
      S_WB: begin
        write_reg = 1'b1;
        if (ir[15:12] == RD_PC) begin
          write_pc = 1'b1;
          pc_s     = PCS_ALU;
        end
        boundary = 1'b1;
      end
      S_MADDR: begin
        alu_en = 1'b1;
        wd_clr = 1'b1;
        nxt    = S_MACC;
      end
      S_MACC: begin
        mem_req = 1'b1;
        mem_we  = ~is_load;
        // an ack on the expiring cycle still completes the access
        if (mem_ack) begin
          if (is_load) nxt = S_WB;
          else         boundary = 1'b1;
        end else begin
          wd_en = 1'b1;
          if (wd_exp) nxt = S_FAULT;
        end
      end
      S_BRANCH: begin
        write_pc = 1'b1;
        pc_s     = PCS_BR;
        if (ir[24]) begin
          write_reg = 1'b1;
          link_sel  = 1'b1;
        end
        boundary = 1'b1;
      end
      S_FAULT: begin
        nxt = S_FAULT;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
    if (boundary) begin
      nxt = halt_req ? S_IDLE : S_FETCH;
    end
  end

  assign busy    = (cur != S_IDLE) && (cur != S_FAULT);
  assign fault   = (cur == S_FAULT);
  assign state   = cur;
  assign retired = retired_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: WDOG_MAX, default 8'd255, memory-ack timeout in cycles.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous reset, active-low (asserted when 0).
REQ-004 start  in  1  leave IDLE and begin fetching.
REQ-005 halt_req  in  1  stop at next instruction boundary.
REQ-006 ir  in  32  current instruction register from fetch unit.
REQ-007 cond_ok  in  1  condition-pass flag from fetch unit, valid during FETCH.
REQ-008 mem_ack  in  1  data-memory completion.
REQ-009 write_ir, write_pc  out  1 each  fetch-unit strobes.
REQ-010 pc_s  out  2  PC source: 00 PC+4, 01 branch target, 10 ALU result.
REQ-011 alu_en, set_flags, write_reg, link_sel, mem_req, mem_we  out  1 each  datapath strobes.
REQ-012 busy, fault  out  1 each  status.
REQ-013 state  out  4  current state encoding, debug.
REQ-014 retired  out  32  count of completed instructions.

Function
REQ-015 Moore FSM; all strobe outputs SHALL be pure decode of the registered state and ir; non-listed strobes 0.
REQ-016 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, MADDR=5, MACC=6, BRANCH=7, FAULT=8.
REQ-017 IDLE: busy=0; start=1 -> FETCH next cycle.
REQ-018 FETCH: write_ir=1, write_pc=1, pc_s=00; cond_ok latched into cond_q; -> DECODE.
REQ-019 DECODE: cond_q=0 -> boundary (instruction skipped, retired+1); else class ir[27:26]: 00 -> EXEC, 01 -> MADDR, 10 -> BRANCH, 11 -> FAULT.
REQ-020 EXEC: alu_en=1, set_flags=ir[20]; -> WB.
REQ-021 WB: write_reg=1; if ir[15:12]==4'hF also write_pc=1, pc_s=10; -> boundary.
REQ-022 MADDR: alu_en=1, set_flags=0; -> MACC; watchdog cleared.
REQ-023 MACC: mem_req=1, mem_we=~ir[20]; hold until mem_ack=1; ack with ir[20]=1 (load) -> WB, ir[20]=0 (store) -> boundary.
REQ-024 MACC watchdog: 8-bit counter increments each MACC cycle without ack; reaching WDOG_MAX -> FAULT; ack on the WDOG_MAX cycle wins.
REQ-025 BRANCH: write_pc=1, pc_s=01; ir[24]=1 also write_reg=1, link_sel=1; -> boundary.
REQ-026 Boundary: retired increments by 1 (wraps 0xFFFFFFFF -> 0); halt_req=1 sampled that cycle -> IDLE, else FETCH.
REQ-027 halt_req outside boundary cycles SHALL have no effect; it is not latched.
REQ-028 FAULT: fault=1, busy=0, all strobes 0; sticky until reset; start ignored.
REQ-029 busy=1 in every state except IDLE and FAULT.
REQ-030 mem_ack outside MACC SHALL be ignored.

Reset
REQ-031 rst=0 SHALL immediately force state=IDLE, cond_q=0, watchdog=0, retired=0, fault=0, all strobes 0, regardless of current state (including mid-MACC).
REQ-032 Release of rst SHALL take effect at the next posedge; no strobe pulses during or on release.

Structure
REQ-033 Package instr_seq_pkg: state encodings, class codes (DP, MEM, BR, RSV), pc_s codes, WDOG default.
REQ-034 One sub-module, seq_watchdog (clear, enable, max -> expired), instantiated once.
REQ-035 Target size 150-300 lines RTL.

Verification
REQ-036 Reset, start=1, ir=0xE0810002 (DP, AL), cond_ok=1 -> states 1,2,3,4,1; alu_en in EXEC, write_reg in WB, retired=1.
REQ-037 ir=0x0A000004 (BEQ), cond_ok=0 -> FETCH, DECODE, FETCH; no write_pc beyond FETCH, retired+1.
REQ-038 ir=0xEB000010 (BL) -> BRANCH with write_pc=1, pc_s=01, write_reg=1, link_sel=1.
REQ-039 ir=0xE5910000 (LDR), mem_ack after 3 cycles -> MACC for 4 cycles, mem_we=0, then WB; with no ack -> FAULT after 255 MACC cycles, fault=1 sticky.
REQ-040 ir=0xE081F002 (Rd=PC) -> WB asserts write_pc=1, pc_s=10; halt_req=1 in WB -> IDLE, busy=0.
REQ-041 rst=0 asserted mid-MACC with mem_req=1 -> mem_req=0 and state=0 immediately; retired preset to 0xFFFFFFFF via forced count -> one instruction wraps to 0.
